// File: rtl/alu_muldiv_if.sv
// Execute-stage <-> multiply/divide unit bundle: decode fields, operands, stall/done handshake.
interface alu_muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            req_i;
    logic            flush_i;
    logic            ALUAdd;
    logic            Branch;
    logic            ALUOp;
    logic [6:0]      funct7;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            md_sel_o;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output req_i, flush_i, ALUAdd, Branch, ALUOp, funct7, funct3, op_a, op_b,
        input  md_sel_o, stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  req_i, flush_i, ALUAdd, Branch, ALUOp, funct7, funct3, op_a, op_b,
        output md_sel_o, stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide on magnitudes).
// Define ALU_MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [XLEN-1:0] ZERO_X   = '0;
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              md_sel;
    logic              start;
    logic              in_div;
    logic              a_signed, b_signed;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              b_zero, ovf, special;
    logic [XLEN-1:0]   spec_val;
    logic [XLEN-1:0]   add_val;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_tmp, div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] mul_res;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   fin_res;
`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
`endif

    always_comb begin
        md_sel = ~bus.ALUAdd & ~bus.Branch & ~bus.ALUOp & (bus.funct7 == 7'b0000001);
        // The done cycle is still IDLE with req_i high; the held instruction must not restart.
        start  = bus.req_i & md_sel & ~bus.flush_i & ~done_q;
        in_div = bus.funct3[2];

        a_signed = 1'b0;
        b_signed = 1'b0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010:                 a_signed = 1'b1;
            default:                ;
        endcase
        neg_a = a_signed & bus.op_a[XLEN-1];
        neg_b = b_signed & bus.op_b[XLEN-1];
        mag_a = neg_a ? -bus.op_a : bus.op_a;
        mag_b = neg_b ? -bus.op_b : bus.op_b;

        b_zero  = (bus.op_b == ZERO_X);
        ovf     = in_div & ~bus.funct3[0] & (bus.op_a == MIN_NEG) & (bus.op_b == ALL_ONES);
        special = in_div & (b_zero | ovf);
        if (b_zero)
            spec_val = bus.funct3[1] ? bus.op_a : ALL_ONES;
        else
            spec_val = bus.funct3[1] ? ZERO_X : bus.op_a;
    end

`ifdef ALU_MULDIV_FAST_MUL_EN
    always_comb begin
        fast_prod = {ZERO_X, mag_a} * {ZERO_X, mag_b};
    end
`endif

    // One iteration step; prod_q is {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        add_val  = prod_q[0] ? opnd_q : ZERO_X;
        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, add_val};
        mul_next = {mul_sum, prod_q[XLEN-1:1]};

        div_tmp  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_diff = div_tmp - {1'b0, opnd_q};
        div_ok   = ~div_diff[XLEN];
        div_next = {(div_ok ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0]),
                    prod_q[XLEN-2:0], div_ok};
    end

    always_comb begin
        mul_res = neg_res_q ? -prod_q : prod_q;
        quo     = prod_q[XLEN-1:0];
        rem     = prod_q[2*XLEN-1:XLEN];
        case (f3_q)
            3'b000:         fin_res = mul_res[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         fin_res = mul_res[2*XLEN-1:XLEN];
            3'b100, 3'b101: fin_res = neg_res_q ? -quo : quo;
            default:        fin_res = neg_rem_q ? -rem : rem;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        prod_d    = prod_q;
        opnd_d    = opnd_q;
        f3_d      = f3_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    f3_d      = bus.funct3;
                    neg_res_d = neg_a ^ neg_b;
                    neg_rem_d = neg_a;
                    count_d   = '0;
                    if (special) begin
                        // Both halves carry the answer so quotient and remainder reads agree.
                        prod_d    = {spec_val, spec_val};
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = S_DONE;
                    end
`ifdef ALU_MULDIV_FAST_MUL_EN
                    else if (!in_div) begin
                        prod_d  = fast_prod;
                        state_d = S_DONE;
                    end
`endif
                    else begin
                        prod_d  = in_div ? {ZERO_X, mag_a} : {ZERO_X, mag_b};
                        opnd_d  = in_div ? mag_b : mag_a;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d  = f3_q[2] ? div_next : mul_next;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_CNT)
                        state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!bus.flush_i) begin
                    done_d   = 1'b1;
                    result_d = fin_res;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            prod_q    <= '0;
            opnd_q    <= '0;
            f3_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            prod_q    <= prod_d;
            opnd_q    <= opnd_d;
            f3_q      <= f3_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign bus.md_sel_o = md_sel;
    assign bus.stall_o  = bus.req_i & md_sel & ~done_q & ~bus.flush_i;
    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
endmodule
